// File: rtl/lector_salidas_if.sv
// Egress-side bus bundle for lector_salidas: FIFO read side plus the valid/ready stream to the sink.
// master = the reader; slave = FIFOs and sink.
interface lector_salidas_if #(
    parameter int TAMANO_DATOS = 12
) ();
    logic [3:0]              empty;
    logic [TAMANO_DATOS-1:0] data_in0;
    logic [TAMANO_DATOS-1:0] data_in1;
    logic [TAMANO_DATOS-1:0] data_in2;
    logic [TAMANO_DATOS-1:0] data_in3;
    logic [3:0]              pop;
    logic [TAMANO_DATOS-1:0] data_out;
    logic                    valid;
    logic                    ready;
    logic [1:0]              puerto;

    modport master (
        input  empty, data_in0, data_in1, data_in2, data_in3, ready,
        output pop, data_out, valid, puerto
    );

    modport slave (
        output empty, data_in0, data_in1, data_in2, data_in3, ready,
        input  pop, data_out, valid, puerto
    );
endinterface

// File: rtl/lector_salidas.sv
// Round-robin reader draining four output FIFOs onto one valid/ready stream, with per-port counters.
// Optional CHECK_DEST_EN macro: sticky error_dest when a word's dest field differs from its source FIFO.
module lector_salidas #(
    parameter int TAMANO_DATOS = 12,
    parameter int ANCHO_CONT   = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    lector_salidas_if.master        bus,
    output logic [4*ANCHO_CONT-1:0] cuenta,
    output logic                    idle,
    output logic                    error_dest
);
    typedef enum logic [1:0] {IDLE, POP, CAPT, OUT} estado_t;

    estado_t                 state_q, state_d;
    logic [1:0]              grant_q, grant_d;
    logic [1:0]              rr_q, rr_d;
    logic [TAMANO_DATOS-1:0] data_q, data_d;
    logic                    valid_q, valid_d;
    logic [1:0]              puerto_q, puerto_d;
    logic [4*ANCHO_CONT-1:0] cuenta_q, cuenta_d;
    logic [TAMANO_DATOS-1:0] dato_sel;
    logic [3:0]              pop_o;
    logic                    hay_datos;

    // First non-empty FIFO after base, circularly; base itself is checked last.
    function automatic logic [1:0] arbitra(input logic [1:0] base, input logic [3:0] vacio);
        logic [1:0] sel;
        logic [1:0] idx;
        sel = base + 2'd1;
        for (int unsigned k = 4; k >= 1; k--) begin
            idx = base + k[1:0];
            if (!vacio[idx]) sel = idx;
        end
        return sel;
    endfunction

    assign hay_datos = |(~bus.empty);

    always_comb begin
        dato_sel = bus.data_in0;
        case (grant_q)
            2'd0:    dato_sel = bus.data_in0;
            2'd1:    dato_sel = bus.data_in1;
            2'd2:    dato_sel = bus.data_in2;
            default: dato_sel = bus.data_in3;
        endcase
    end

`ifdef CHECK_DEST_EN
    logic err_q, err_d;
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        data_d   = data_q;
        valid_d  = valid_q;
        puerto_d = puerto_q;
        cuenta_d = cuenta_q;
`ifdef CHECK_DEST_EN
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (enable && hay_datos) begin
                    grant_d = arbitra(rr_q, bus.empty);
                    state_d = POP;
                end
            end
            POP: begin
                state_d = bus.empty[grant_q] ? IDLE : CAPT;
            end
            CAPT: begin
                data_d   = dato_sel;
                puerto_d = grant_q;
                valid_d  = 1'b1;
                state_d  = OUT;
`ifdef CHECK_DEST_EN
                if (dato_sel[TAMANO_DATOS-3 -: 2] != grant_q) err_d = 1'b1;
`endif
            end
            OUT: begin
                if (valid_q && bus.ready) begin
                    for (int unsigned i = 0; i < 4; i++) begin
                        if (puerto_q == i[1:0])
                            cuenta_d[i*ANCHO_CONT +: ANCHO_CONT] =
                                cuenta_q[i*ANCHO_CONT +: ANCHO_CONT] + ANCHO_CONT'(1);
                    end
                    rr_d    = puerto_q;
                    valid_d = 1'b0;
                    // Arbitrate from the port just served so it drops to lowest priority.
                    if (enable && hay_datos) begin
                        grant_d = arbitra(puerto_q, bus.empty);
                        state_d = POP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_q     <= 2'd3;
            data_q   <= '0;
            valid_q  <= 1'b0;
            puerto_q <= '0;
            cuenta_q <= '0;
`ifdef CHECK_DEST_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            puerto_q <= puerto_d;
            cuenta_q <= cuenta_d;
`ifdef CHECK_DEST_EN
            err_q    <= err_d;
`endif
        end
    end

    // The read strobe is combinational so reset can suppress it in the same cycle.
    always_comb begin
        pop_o = '0;
        if (state_q == POP && !bus.empty[grant_q] && !reset) pop_o[grant_q] = 1'b1;
    end

    assign bus.pop      = pop_o;
    assign bus.data_out = data_q;
    assign bus.valid    = valid_q;
    assign bus.puerto   = puerto_q;
    assign cuenta       = cuenta_q;
    assign idle         = (state_q == IDLE);

`ifdef CHECK_DEST_EN
    assign error_dest = err_q;
`else
    assign error_dest = 1'b0;
`endif
endmodule

// File: tb/tb_lector_salidas.sv
// Directed bench for lector_salidas: FIFO models feed the DUT, a scoreboard queue checks each accepted word.
// Expected error_dest follows the CHECK_DEST_EN macro.
module tb_lector_salidas;
    localparam int TD = 12;
    localparam int AC = 5;
`ifdef CHECK_DEST_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          ready;
    logic          flush;
    logic [4*AC-1:0] cuenta;
    logic          idle;
    logic          error_dest;

    lector_salidas_if #(.TAMANO_DATOS(TD)) bus ();

    lector_salidas #(.TAMANO_DATOS(TD), .ANCHO_CONT(AC)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .bus        (bus),
        .cuenta     (cuenta),
        .idle       (idle),
        .error_dest (error_dest)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [TD-1:0]   fifo [4][$];
    logic [TD+1:0]   pend [$];
    logic [TD+1:0]   exp_q [$];
    logic [3:0]      empty_m = 4'hF;
    logic [TD-1:0]   d_m [4];

    assign bus.empty    = empty_m;
    assign bus.data_in0 = d_m[0];
    assign bus.data_in1 = d_m[1];
    assign bus.data_in2 = d_m[2];
    assign bus.data_in3 = d_m[3];
    assign bus.ready    = ready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // FIFO model: data appears the cycle after read_enable; pushes land on the next edge.
    always @(posedge clk) begin
        if (flush) begin
            for (int i = 0; i < 4; i++) fifo[i].delete();
            pend.delete();
        end
        for (int i = 0; i < 4; i++)
            if (bus.pop[i] && fifo[i].size() > 0) d_m[i] <= fifo[i].pop_front();
        while (pend.size() > 0) begin
            logic [TD+1:0] e;
            e = pend.pop_front();
            fifo[e[TD+1:TD]].push_back(e[TD-1:0]);
        end
        for (int i = 0; i < 4; i++) empty_m[i] <= (fifo[i].size() == 0);
    end

    logic [TD+1:0] mon_e;
    always @(negedge clk) begin
        if (reset) begin
            check("pop_in_reset", 32'(bus.pop), 32'h0);
        end else begin
            check("pop_onehot", 32'($onehot0(bus.pop)), 32'h1);
            if (bus.valid && bus.ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'h0, 32'h1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("data_out", 32'(bus.data_out), 32'(mon_e[TD-1:0]));
                    check("puerto", 32'(bus.puerto), 32'(mon_e[TD+1:TD]));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int p, input logic [TD-1:0] d, input bit scored);
        pend.push_back({p[1:0], d});
        if (scored) exp_q.push_back({p[1:0], d});
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc, input string tag);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && idle && empty_m == 4'hF && !bus.valid) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 32'(ok), 32'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        ready  = 1'b1;
        flush  = 1'b0;

        // Reset with all FIFOs loaded, then round-robin drain from rr_ptr=3.
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++)
                push(i, {k[1:0], i[1:0], 8'(16 * i + k)}, 1'b1);
        step();
        @(negedge clk);
        check("rst_pop", 32'(bus.pop), 32'h0);
        check("rst_valid", 32'(bus.valid), 32'h0);
        check("rst_err", 32'(error_dest), 32'h0);
        step();
        @(negedge clk);
        check("rst_pop2", 32'(bus.pop), 32'h0);
        check("rst_valid2", 32'(bus.valid), 32'h0);
        check("rst_empty_seen", 32'(empty_m), 32'h0);
        reset = 1'b0;
        #1;
        check("rst_cuenta", 32'(cuenta), 32'h0);
        wait_drain(150, "t3_drain");
        check("t3_cuenta", 32'(cuenta), 32'({4{5'd2}}));

        // Single word through FIFO2: pop, then valid two cycles later.
        do_reset();
        push(2, 12'h6A5, 1'b1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.pop != 4'h0) break;
        end
        check("t2_pop", 32'(bus.pop), 32'h4);
        @(negedge clk);
        check("t2_capt_valid", 32'(bus.valid), 32'h0);
        @(negedge clk);
        check("t2_valid", 32'(bus.valid), 32'h1);
        check("t2_data", 32'(bus.data_out), 32'h6A5);
        check("t2_puerto", 32'(bus.puerto), 32'h2);
        wait_drain(50, "t2_drain");
        check("t2_cuenta", 32'(cuenta), 32'(1) << (2 * AC));

        // Backpressure: hold ready low for five cycles with a word waiting.
        do_reset();
        ready = 1'b0;
        push(1, 12'h1AB, 1'b1);
        push(3, 12'h3C4, 1'b1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.valid) break;
        end
        check("t4_valid", 32'(bus.valid), 32'h1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t4_hold_valid", 32'(bus.valid), 32'h1);
            check("t4_hold_data", 32'(bus.data_out), 32'h1AB);
            check("t4_no_pop", 32'(bus.pop), 32'h0);
            check("t4_cuenta_hold", 32'(cuenta), 32'h0);
        end
        ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t4_cuenta_once", 32'(cuenta), 32'(1) << AC);
        wait_drain(50, "t4_drain");
        check("t4_cuenta", 32'(cuenta), (32'(1) << AC) | (32'(1) << (3 * AC)));

        // 33 words through port 1 wrap its 5-bit counter to 1.
        do_reset();
        for (int n = 0; n < 33; n++) push(1, {2'b00, 2'b01, 8'(n)}, 1'b1);
        wait_drain(400, "t5_drain");
        check("t5_wrap", 32'(cuenta), 32'(1) << AC);

        // Reset landing in the POP cycle suppresses the read.
        step();
        push(0, 12'h055, 1'b0);
        step();
        step();
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        check("t5_in_pop", 32'(idle), 32'h0);
        check("t5_pop_gated", 32'(bus.pop), 32'h0);
        @(negedge clk);
        check("t5_valid_after", 32'(bus.valid), 32'h0);
        check("t5_idle_after", 32'(idle), 32'h1);
        flush = 1'b1;
        step();
        flush  = 1'b0;
        reset  = 1'b0;
        enable = 1'b1;

        // Dest mismatch from FIFO0, then a clean word: flag must stick.
        push(0, 12'h300, 1'b1);
        wait_drain(50, "t6_drain");
        check("t6_err", 32'(error_dest), 32'(EXP_ERR));
        check("t6_cuenta", 32'(cuenta), 32'h1);
        push(0, 12'h012, 1'b1);
        wait_drain(50, "t6_drain2");
        check("t6_sticky", 32'(error_dest), 32'(EXP_ERR));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
